// File: rtl/scope_pkg.sv
// ---------------------------------------------------------------------------
// scope_pkg
// Shared types and constants for the oscilloscope trace renderer.
//   rgb12_t        : 12-bit RGB 4:4:4 pixel
//   H_ACTIVE       : active pixels per line (ring depth default)
//   V_ACTIVE       : active lines per frame
//   TRACE_RGB_DEF  : default trace colour
//   GRID_RGB       : graticule colour (used when SCOPE_GRID_EN is defined)
//   sample_row()   : screen row of a sample, BASELINE - s, 11-bit signed
// ---------------------------------------------------------------------------
package scope_pkg;

  typedef logic [11:0] rgb12_t;

  localparam int unsigned H_ACTIVE      = 640;
  localparam int unsigned V_ACTIVE      = 480;
  localparam rgb12_t      TRACE_RGB_DEF = 12'h0F0;
  localparam rgb12_t      GRID_RGB      = 12'h333;

  // Larger samples plot higher on screen, i.e. at a smaller row index.
  function automatic logic signed [10:0] sample_row(input logic [7:0] s,
                                                    input int unsigned baseline);
    return $signed(11'(baseline)) - $signed({3'b000, s});
  endfunction

endpackage

// File: rtl/scope_ring_ram.sv
// ---------------------------------------------------------------------------
// scope_ring_ram
// Simple dual-port RAM (one write port, one registered read port) holding the
// sample ring. A read and a write to the same address in one cycle return the
// old contents. Written to map onto a block RAM.
// Ports:
//   vga_clock : clock
//   we        : write enable
//   wr_addr   : write address
//   wr_data   : write data
//   rd_addr   : read address
//   rd_data   : read data, valid one cycle after rd_addr
// ---------------------------------------------------------------------------
module scope_ring_ram #(
  parameter int unsigned DEPTH = 640,
  parameter int unsigned AW    = 10,
  parameter int unsigned DW    = 8
) (
  input  logic          vga_clock,
  input  logic          we,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data
);

  logic [DW-1:0] mem [DEPTH];

  // NOTE: the array is deliberately left out of reset; a resettable memory
  // cannot map onto block RAM, and the fill count masks stale entries anyway.
  always_ff @(posedge vga_clock) begin
    if (we) mem[wr_addr] <= wr_data;
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/scope_trace_renderer.sv
// ---------------------------------------------------------------------------
// scope_trace_renderer
// Pixel stage behind a 640x480 VGA timing generator. Samples are written into
// a ring buffer and drawn as a scrolling trace, oldest sample at the left.
// Every output lags its inputs by exactly two vga_clock cycles.
// Optional build macro: SCOPE_GRID_EN adds a 64-pixel graticule.
// Ports:
//   vga_clock, reset_n          : clock, asynchronous active-low reset
//   hcount, vcount              : raster position from the timing generator
//   hsync_in, vsync_in          : syncs from the timing generator
//   at_display_area             : high on active pixels
//   sample, sample_valid        : sample stream, single-cycle strobe
//   freeze                      : drop incoming samples while high
//   pixel                       : RGB 4:4:4 output
//   hsync_out, vsync_out        : syncs aligned to pixel
// ---------------------------------------------------------------------------
module scope_trace_renderer import scope_pkg::*; #(
  parameter int unsigned H_START   = 144,
  parameter int unsigned V_START   = 35,
  parameter int unsigned DEPTH     = H_ACTIVE,
  parameter int unsigned BASELINE  = 367,
  parameter rgb12_t      TRACE_RGB = TRACE_RGB_DEF
) (
  input  logic       vga_clock,
  input  logic       reset_n,
  input  logic [9:0] hcount,
  input  logic [9:0] vcount,
  input  logic       hsync_in,
  input  logic       vsync_in,
  input  logic       at_display_area,
  input  logic [7:0] sample,
  input  logic       sample_valid,
  input  logic       freeze,
  output rgb12_t     pixel,
  output logic       hsync_out,
  output logic       vsync_out
);

  localparam logic [9:0]  LAST_IDX = 10'(DEPTH - 1);
  localparam logic [9:0]  FULL_CNT = 10'(DEPTH);
  localparam logic [10:0] DEPTH_11 = 11'(DEPTH);

  // ---------------- write side and per-frame latch ----------------
  logic [9:0] wr_ptr, fill, base, cols;
  logic       wr_en, frame_start;

  assign wr_en       = sample_valid && !freeze;
  assign frame_start = (hcount == 10'd0) && (vcount == 10'd0);

  // NOTE: every register is updated with <= so the frame latch below sees the
  // pre-write wr_ptr/fill when a write lands in the same cycle.
  always_ff @(posedge vga_clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      fill   <= '0;
      base   <= '0;
      cols   <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= (wr_ptr == LAST_IDX) ? 10'd0 : wr_ptr + 10'd1;
        if (fill != FULL_CNT) fill <= fill + 10'd1;
      end
      // Once the ring is full the oldest sample sits at wr_ptr; before that it
      // is entry 0. Holding base for the frame keeps the image from tearing.
      if (frame_start) begin
        base <= (fill == FULL_CNT) ? wr_ptr : 10'd0;
        cols <= fill;
      end
    end
  end

  // ---------------- stage 0: address generation ----------------
  logic [9:0]         x, rd_addr;
  logic [10:0]        addr_sum;
  logic signed [10:0] y;
  logic               x_valid;

  assign x        = hcount - 10'(H_START);
  assign y        = $signed({1'b0, vcount}) - $signed(11'(V_START));
  assign x_valid  = at_display_area && (hcount >= 10'(H_START)) && (x < cols);
  assign addr_sum = {1'b0, base} + {1'b0, x};
  // base and x are both below DEPTH, so one conditional subtract wraps.
  assign rd_addr  = !x_valid ? 10'd0 :
                    (addr_sum >= DEPTH_11) ? 10'(addr_sum - DEPTH_11) : addr_sum[9:0];

  logic [7:0] cur;

  scope_ring_ram #(.DEPTH(DEPTH), .AW(10), .DW(8)) u_ram (
    .vga_clock (vga_clock),
    .we        (wr_en),
    .wr_addr   (wr_ptr),
    .wr_data   (sample),
    .rd_addr   (rd_addr),
    .rd_data   (cur)
  );

  // ---------------- stage 1: align side-band with RAM data ----------------
  logic signed [10:0] y_q;
  logic               xv_q, x0_q, disp_q, hs_q, vs_q;
`ifdef SCOPE_GRID_EN
  logic               grid_q;
`endif

  always_ff @(posedge vga_clock or negedge reset_n) begin
    if (!reset_n) begin
      y_q    <= '0;
      xv_q   <= 1'b0;
      x0_q   <= 1'b0;
      disp_q <= 1'b0;
      hs_q   <= 1'b0;
      vs_q   <= 1'b0;
`ifdef SCOPE_GRID_EN
      grid_q <= 1'b0;
`endif
    end else begin
      y_q    <= y;
      xv_q   <= x_valid;
      x0_q   <= (x == 10'd0);
      disp_q <= at_display_area;
      hs_q   <= hsync_in;
      vs_q   <= vsync_in;
`ifdef SCOPE_GRID_EN
      grid_q <= (x[5:0] == 6'd0) || (y[5:0] == 6'd0);
`endif
    end
  end

  // ---------------- stage 2: segment test and output ----------------
  logic [7:0]         prev, prev_eff;
  logic signed [10:0] r_cur, r_prev, r_lo, r_hi;
  logic               lit;
  rgb12_t             pixel_next;

  // Column 0 has no left neighbour, so it collapses to a single point.
  assign prev_eff = x0_q ? cur : prev;
  assign r_cur    = sample_row(cur, BASELINE);
  assign r_prev   = sample_row(prev_eff, BASELINE);
  assign r_lo     = (r_cur < r_prev) ? r_cur : r_prev;
  assign r_hi     = (r_cur < r_prev) ? r_prev : r_cur;
  // Vertical span between neighbouring samples keeps steep edges connected.
  assign lit      = xv_q && (y_q >= r_lo) && (y_q <= r_hi);

  // NOTE: pixel_next gets a default before any branch so no latch is inferred.
  always_comb begin
    pixel_next = '0;
    if (disp_q) begin
      if (lit) pixel_next = TRACE_RGB;
`ifdef SCOPE_GRID_EN
      else if (grid_q) pixel_next = GRID_RGB;
`endif
    end
  end

  always_ff @(posedge vga_clock or negedge reset_n) begin
    if (!reset_n) begin
      prev      <= '0;
      pixel     <= '0;
      hsync_out <= 1'b0;
      vsync_out <= 1'b0;
    end else begin
      if (xv_q) prev <= cur;
      pixel     <= pixel_next;
      hsync_out <= hs_q;
      vsync_out <= vs_q;
    end
  end

endmodule

// File: tb/tb_scope_trace_renderer.sv
// ---------------------------------------------------------------------------
// tb_scope_trace_renderer
// Directed bench for scope_trace_renderer. Inputs change on the falling edge
// and outputs are sampled on the falling edge, half a cycle from capture.
// ---------------------------------------------------------------------------
module tb_scope_trace_renderer;
  import scope_pkg::*;

  localparam int H_ST = 144;
  localparam int V_ST = 35;
  localparam rgb12_t TRACE = 12'h0F0;

  logic       vga_clock = 1'b0;
  logic       reset_n;
  logic [9:0] hcount, vcount;
  logic       hsync_in, vsync_in, at_display_area;
  logic [7:0] sample;
  logic       sample_valid, freeze;
  rgb12_t     pixel;
  logic       hsync_out, vsync_out;

  int errors = 0;
  int checks = 0;

  always #5 vga_clock = ~vga_clock;

  scope_trace_renderer dut (
    .vga_clock       (vga_clock),
    .reset_n         (reset_n),
    .hcount          (hcount),
    .vcount          (vcount),
    .hsync_in        (hsync_in),
    .vsync_in        (vsync_in),
    .at_display_area (at_display_area),
    .sample          (sample),
    .sample_valid    (sample_valid),
    .freeze          (freeze),
    .pixel           (pixel),
    .hsync_out       (hsync_out),
    .vsync_out       (vsync_out)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Background colour expected for a non-trace active pixel.
  function automatic rgb12_t bg(input int x, input int y);
`ifdef SCOPE_GRID_EN
    return ((x % 64) == 0 || (y % 64) == 0) ? 12'h333 : 12'h000;
`else
    return 12'h000 + 12'(x * 0) + 12'(y * 0);
`endif
  endfunction

  // Hold one raster position for one clock.
  task automatic cyc(input int h, input int v, input logic d, input logic hs, input logic vs);
    hcount = 10'(h); vcount = 10'(v); at_display_area = d; hsync_in = hs; vsync_in = vs;
    @(negedge vga_clock);
  endtask

  task automatic idle();
    cyc(700, 10, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic latch();
    cyc(0, 0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic write_sample(input int s);
    sample = 8'(s); sample_valid = 1'b1;
    idle();
    sample_valid = 1'b0;
  endtask

  // Scan column x-1 then x on row y; check the pixel of column x.
  task automatic probe(input int x, input int y, input logic d, input rgb12_t exp, input string tag);
    if (x > 0) cyc(H_ST + x - 1, V_ST + y, 1'b1, 1'b0, 1'b0);
    cyc(H_ST + x, V_ST + y, d, 1'b0, 1'b0);
    idle();
    check(tag, 16'(pixel), 16'(exp));
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    @(negedge vga_clock);
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0; sample = '0; sample_valid = 1'b0; freeze = 1'b0;
    hcount = '0; vcount = 10'd10; at_display_area = 1'b1; hsync_in = 1'b1; vsync_in = 1'b1;
    @(negedge vga_clock); @(negedge vga_clock);
    check("rst_pixel", 16'(pixel), 16'h0);
    check("rst_hsync", 16'(hsync_out), 16'h0);
    check("rst_vsync", 16'(vsync_out), 16'h0);
    check("rst_wr_ptr", 16'(dut.wr_ptr), 16'd0);
    check("rst_fill", 16'(dut.fill), 16'd0);
    reset_n = 1'b1;
    idle();

    // ---- partial fill: samples 0,10,20,30,40 ----
    for (int k = 0; k < 5; k++) write_sample(k * 10);
    check("fill5", 16'(dut.fill), 16'd5);
    latch();
    check("cols5", 16'(dut.cols), 16'd5);
    check("base0", 16'(dut.base), 16'd0);
    probe(0, 367, 1'b1, TRACE, "c0_point");
    probe(0, 366, 1'b1, bg(0, 366), "c0_above");
    probe(2, 347, 1'b1, TRACE, "c2_top");
    probe(2, 352, 1'b1, TRACE, "c2_mid");
    probe(2, 357, 1'b1, TRACE, "c2_bot");
    probe(2, 346, 1'b1, bg(2, 346), "c2_above");
    probe(2, 358, 1'b1, bg(2, 358), "c2_below");
    probe(4, 327, 1'b1, TRACE, "c4_top");
    probe(5, 327, 1'b1, bg(5, 327), "c5_unfilled");

    // ---- new sample waits for the next latch ----
    write_sample(50);
    probe(5, 317, 1'b1, bg(5, 317), "c5_before_latch");
    latch();
    probe(5, 317, 1'b1, TRACE, "c5_top");
    probe(5, 322, 1'b1, TRACE, "c5_mid");
    probe(5, 316, 1'b1, bg(5, 316), "c5_above");

    // ---- freeze drops samples ----
    freeze = 1'b1;
    for (int k = 0; k < 50; k++) write_sample(200);
    freeze = 1'b0;
    check("frz_wr_ptr", 16'(dut.wr_ptr), 16'd6);
    check("frz_fill", 16'(dut.fill), 16'd6);
    latch();
    probe(5, 317, 1'b1, TRACE, "frz_c5");
    probe(6, 317, 1'b1, bg(6, 317), "frz_c6");

    // ---- wrap: 700 samples of k mod 256 ----
    do_reset();
    for (int k = 0; k < 700; k++) write_sample(k % 256);
    check("wrap_wr_ptr", 16'(dut.wr_ptr), 16'd60);
    check("wrap_fill", 16'(dut.fill), 16'd640);
    latch();
    check("wrap_base", 16'(dut.base), 16'd60);
    probe(0, 307, 1'b1, TRACE, "wrap_c0");
    probe(1, 306, 1'b1, TRACE, "wrap_c1_top");
    probe(1, 305, 1'b1, bg(1, 305), "wrap_c1_above");
    probe(580, 239, 1'b1, TRACE, "wrap_c580");
    probe(580, 241, 1'b1, bg(580, 241), "wrap_c580_below");
    probe(639, 180, 1'b1, TRACE, "wrap_c639_top");
    probe(639, 181, 1'b1, TRACE, "wrap_c639_bot");
    probe(639, 179, 1'b1, bg(639, 179), "wrap_c639_above");

    // ---- write in the latch cycle ----
    sample = 8'd100; sample_valid = 1'b1;
    latch();
    sample_valid = 1'b0;
    check("sim_base", 16'(dut.base), 16'd60);
    check("sim_wr_ptr", 16'(dut.wr_ptr), 16'd61);
    probe(0, 267, 1'b1, TRACE, "sim_c0");
    probe(1, 290, 1'b1, TRACE, "sim_c1_span");
    probe(0, 267, 1'b0, 12'h000, "blank_outside");

    // ---- latency: one lit pixel with sync pulses ----
    idle();
    cyc(H_ST, V_ST + 267, 1'b1, 1'b1, 1'b1);
    check("lat1_pixel", 16'(pixel), 16'h0);
    check("lat1_hsync", 16'(hsync_out), 16'h0);
    idle();
    check("lat2_pixel", 16'(pixel), 16'(TRACE));
    check("lat2_hsync", 16'(hsync_out), 16'h1);
    check("lat2_vsync", 16'(vsync_out), 16'h1);
    idle();
    check("lat3_pixel", 16'(pixel), 16'h0);
    check("lat3_hsync", 16'(hsync_out), 16'h0);

    // ---- reset mid-frame at vcount 200 ----
    cyc(H_ST + 10, 200, 1'b1, 1'b1, 1'b1);
    cyc(H_ST + 11, 200, 1'b1, 1'b1, 1'b1);
    cyc(H_ST + 12, 200, 1'b1, 1'b1, 1'b1);
    check("pre_rst_hsync", 16'(hsync_out), 16'h1);
    reset_n = 1'b0;
    #1;
    check("mid_rst_hsync", 16'(hsync_out), 16'h0);
    check("mid_rst_vsync", 16'(vsync_out), 16'h0);
    check("mid_rst_pixel", 16'(pixel), 16'h0);
    check("mid_rst_wr_ptr", 16'(dut.wr_ptr), 16'd0);
    check("mid_rst_cols", 16'(dut.cols), 16'd0);
    @(negedge vga_clock);
    reset_n = 1'b1;
    probe(0, 267, 1'b1, bg(0, 267), "post_rst_empty");
    write_sample(100);
    probe(0, 267, 1'b1, bg(0, 267), "post_rst_no_latch");
    latch();
    probe(0, 267, 1'b1, TRACE, "post_rst_lit");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/scope_trace_renderer.md
# scope_trace_renderer

- Pixel-generation stage directly downstream of the 640x480 VGA timing generator.
- Accepts a stream of 8-bit heart-signal samples into a 640-entry ring buffer and renders it as a scrolling oscilloscope trace.
- Consumes `hcount`/`vcount`/`hsync`/`vsync`/`at_display_area` from the timing generator.
- Emits a 12-bit RGB pixel and matching syncs, all delayed by a fixed 2-cycle pipeline.

## Interface
- `H_START`, 144: first active `hcount`.
- `V_START`, 35: first active `vcount`.
- `DEPTH`, 640: ring-buffer entries, equal to the active width.
- `BASELINE`, 367: active row plotted for sample value 0.
- `TRACE_RGB`, 12'h0F0: trace colour.
- `vga_clock` in 1: pixel clock; the only clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `hcount` in 10: pixel index from the timing generator.
- `vcount` in 10: line index from the timing generator.
- `hsync_in`, `vsync_in`, `at_display_area` in 1 each: timing-generator flags.
- `sample` in 8: unsigned signal sample.
- `sample_valid` in 1: single-cycle write strobe.
- `freeze` in 1: while high, incoming samples are dropped (display holds).
- `pixel` out 12: RGB 4:4:4.
- `hsync_out`, `vsync_out` out 1 each: syncs aligned to `pixel`.

## Operation
- **Write side:**
  - `sample_valid && !freeze` writes `sample` at `wr_ptr`, then `wr_ptr` advances and wraps 639->0.
  - `fill` saturates at 640.
- **Frame latch** at `hcount==0 && vcount==0`:
  - `base` <= (`fill`==640) ? `wr_ptr` : 0.
  - `cols` <= `fill`.
  - If a write occurs in the same cycle, the latch uses the pre-write `wr_ptr`/`fill`.
  - Data writes during a frame are visible; `base` is constant for the whole frame, so the display does not shift mid-frame.
- **Column/row mapping:**
  - x = `hcount`-`H_START`, y = `vcount`-`V_START`.
  - RAM read address = (`base`+x) mod 640, computed with a conditional subtract; no divider.
- **Sample row:** r(s) = `BASELINE`-s, an 11-bit signed intermediate.
- **Lit pixel:** requires `at_display_area`, x < `cols`, and y between min(r(cur), r(prev)) and max(r(cur), r(prev)) inclusive.
  - `prev` is the previous column's sample.
  - At x==0, `prev`=`cur`, so a single point is drawn.
- **Pixel value:** lit -> `TRACE_RGB`; else background 12'h000 (or grid, see Configuration). Outside the display area the pixel is forced to 0.
- **Reset values:**
  - `wr_ptr`, `fill`, `base`, `cols`, `prev`: 0.
  - `pixel`, `hsync_out`, `vsync_out`: 0.
  - RAM contents are not reset; `fill`=0 masks them.
- **Reset asserted mid-frame:** all registers clear at once; after release, rendering resumes at the next active pixel with an empty trace until the next frame latch.

## Timing
- Inputs sampled at cycle n.
- Synchronous RAM read data is valid at n+1, together with registered y, x-valid, flag and sync copies.
- `pixel`, `hsync_out` and `vsync_out` are registered at n+2. Fixed latency is 2 cycles for every signal.
- Write-to-display latency: a sample written in frame f appears from the next latched frame when `fill`<640; it is visible in f for columns not yet scanned.
- Single-port RAM plus a separate write port (simple dual-port): a read and a write to the same address in the same cycle return the old data.
- No backpressure: `sample_valid` is always accepted unless `freeze` is high.

## Configuration
- **`SCOPE_GRID_EN`:**
  - Defined: non-trace active pixels with x[5:0]==0 or y[5:0]==0 output 12'h333. The trace has priority over the grid.
  - Undefined: background is always 12'h000, and the grid logic is absent.

## Structure
- Shared package `scope_pkg`:
  - `rgb12_t` typedef.
  - `H_ACTIVE`=640 and `V_ACTIVE`=480 constants.
  - Default colours `TRACE_RGB_DEF` and `GRID_RGB`.
- Sub-module `scope_ring_ram`: 640x8 simple dual-port RAM with registered read, one write port, inferable as block RAM.

## Test plan
- **Fill partial:** after reset, write samples 0,10,20,...; at the next frame column 2 lights rows `V_START`+347..`V_START`+357 (segment 10->20), and columns >= `fill` are black.
- **Wrap:** write 700 samples of value k mod 256; the next frame has `base`=60, column 0 shows sample #60, and `wr_ptr`=60.
- **Latency:** hold a single active pixel lit; `pixel`, `hsync_out` and `vsync_out` transitions all lag the inputs by exactly 2 cycles.
- **Freeze:** raise `freeze`, pulse `sample_valid` 50 times; `wr_ptr`, `fill` and the rendered image are unchanged.
- **Simultaneous latch and write:** a write at `hcount`=`vcount`=0 with `fill`=640 gives `base` = old `wr_ptr`.
- **Reset mid-frame:** assert `reset_n`=0 at `vcount`=200; outputs go 0 immediately, and after release active pixels stay black until new samples are written and a frame latch occurs.
